// File: rtl/imem_loadable_pkg.sv
`default_nettype none
// ============================================================================
// Module  : imem_loadable_pkg
// Brief   : Shared processor constants: loader states, NOP word, instr fields.
// Revision: 1.0
// ============================================================================
package imem_loadable_pkg;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_COUNT = 2'd1;
    localparam logic [1:0] c_ST_HI    = 2'd2;
    localparam logic [1:0] c_ST_LO    = 2'd3;

    localparam logic [15:0] c_NOP_WORD = 16'd2;

    localparam int c_OPC_W = 3;
    localparam int c_RD_W  = 3;
    localparam int c_RS_W  = 3;
    localparam int c_IMM_W = 7;

    typedef struct packed {
        logic [c_OPC_W-1:0] opc;
        logic [c_RD_W-1:0]  rd;
        logic [c_RS_W-1:0]  rs;
        logic [c_IMM_W-1:0] imm;
    } instr_t;

    // A count byte of zero, or one larger than the memory, means "fill it all".
    function automatic logic [8:0] clamp_count(input logic [7:0] b, input logic [8:0] depth);
        logic [8:0] n;
        n = {1'b0, b};
        if (n == 9'd0 || n > depth) begin
            return depth;
        end
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/imem_ram.sv
`default_nettype none
// ============================================================================
// Module  : imem_ram
// Brief   : Single write port / single registered read port instruction store.
// Revision: 1.0
// ============================================================================
module imem_ram #(
    parameter int          ADDR_BITS = 6,
    parameter logic [15:0] INIT_WORD = 16'd2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_we,
    input  logic [ADDR_BITS-1:0] i_waddr,
    input  logic [15:0]          i_wdata,
    input  logic                 i_re,
    input  logic [ADDR_BITS-1:0] i_raddr,
    output logic [15:0]          o_rdata
);

    localparam int c_DEPTH = 2 ** ADDR_BITS;

    // Contents come up as INIT_WORD at configuration and are never cleared by rst.
    logic [15:0] r_mem [c_DEPTH] = '{default: INIT_WORD};
    logic [15:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= 16'd0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/imem_loadable.sv
`default_nettype none
// ============================================================================
// Module  : imem_loadable
// Brief   : Instruction memory with 1-cycle fetch and a byte-stream program loader.
// Revision: 1.0
// ============================================================================
module imem_loadable
    import imem_loadable_pkg::*;
#(
    parameter int          ADDR_BITS = 6,
    parameter logic [15:0] NOP_WORD  = c_NOP_WORD
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [15:0]          iaddr,
    input  logic                 fetch_req,
    output logic [15:0]          idata,
    output logic                 idata_valid,
    input  logic                 load_start,
    input  logic [7:0]           byte_in,
    input  logic                 byte_valid,
    output logic                 busy,
    output logic [ADDR_BITS:0]   load_count
);

    localparam logic [8:0] c_DEPTH = 9'(2 ** ADDR_BITS);

    logic [1:0]           r_state;
    logic [1:0]           w_next;
    logic [7:0]           r_hi;
    logic [8:0]           r_n;
    logic [ADDR_BITS-1:0] r_wptr;
    logic [ADDR_BITS:0]   r_load_count;
    logic                 r_valid;
    logic                 r_oor;
    logic                 w_busy;
    logic                 w_we;
    logic                 w_last;
    logic                 w_accept;
    logic                 w_oor;
    logic [15:0]          w_rdata;

    assign w_last = (9'(r_load_count) + 9'd1) == r_n;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (load_start) begin
            w_next = c_ST_COUNT;
        end else if (byte_valid) begin
            case (r_state)
                c_ST_COUNT: w_next = c_ST_HI;
                c_ST_HI:    w_next = c_ST_LO;
                c_ST_LO:    w_next = w_last ? c_ST_IDLE : c_ST_HI;
                default:    w_next = r_state;
            endcase
        end
    end

    // Write is suppressed under reset so a word completing in the reset cycle is dropped.
    always_comb begin
        w_busy = (r_state != c_ST_IDLE);
        w_we   = (r_state == c_ST_LO) && byte_valid && !load_start && !reset;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_hi         <= 8'd0;
            r_n          <= 9'd0;
            r_wptr       <= '0;
            r_load_count <= '0;
        end else if (load_start) begin
            r_wptr       <= '0;
            r_load_count <= '0;
        end else if (byte_valid) begin
            case (r_state)
                c_ST_COUNT: r_n  <= clamp_count(byte_in, c_DEPTH);
                c_ST_HI:    r_hi <= byte_in;
                c_ST_LO: begin
                    r_load_count <= r_load_count + 1'b1;
                    if (!w_last) begin
                        r_wptr <= r_wptr + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign w_accept = fetch_req && !w_busy;
    assign w_oor    = (iaddr >> (ADDR_BITS + 1)) != 16'd0;

    // r_oor selects between the held RAM read word and NOP for the visible idata.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_oor   <= 1'b0;
        end else begin
            r_valid <= w_accept;
            if (w_accept) begin
                r_oor <= w_oor;
            end
        end
    end

    imem_ram #(
        .ADDR_BITS (ADDR_BITS),
        .INIT_WORD (NOP_WORD)
    ) u_ram (
        .clk     (clock),
        .rst     (reset),
        .i_we    (w_we),
        .i_waddr (r_wptr),
        .i_wdata ({r_hi, byte_in}),
        .i_re    (w_accept && !w_oor),
        .i_raddr (iaddr[ADDR_BITS:1]),
        .o_rdata (w_rdata)
    );

    assign idata       = r_oor ? NOP_WORD : w_rdata;
    assign idata_valid = r_valid;
    assign busy        = w_busy;
    assign load_count  = r_load_count;

endmodule
`default_nettype wire

// File: doc/imem_loadable.md
IMEM_LOADABLE -- requirements
Module: imem_loadable

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 6, word-address width; depth = 2**ADDR_BITS words; legal range 1..8.
REQ-002 SHALL have parameter NOP_WORD, default 16'd2, word returned for out-of-range fetches and stored at configuration.
REQ-003 SHALL have port clock  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port iaddr  input  16  byte address of the instruction; word index = iaddr[ADDR_BITS:1]; iaddr[0] ignored.
REQ-006 SHALL have port fetch_req  input  1  fetch strobe, sampled each cycle.
REQ-007 SHALL have port idata  output  16  fetched instruction word.
REQ-008 SHALL have port idata_valid  output  1  one-cycle pulse: idata updated this cycle.
REQ-009 SHALL have port load_start  input  1  begin (or restart) a program load.
REQ-010 SHALL have port byte_in  input  8  loader byte stream.
REQ-011 SHALL have port byte_valid  input  1  byte_in qualifier, one byte per asserted cycle.
REQ-012 SHALL have port busy  output  1  high while a load is in progress.
REQ-013 SHALL have port load_count  output  ADDR_BITS+1  number of words written by the current or last load.

Function
REQ-014 Fetch latency SHALL be 1 cycle: fetch_req high in cycle N with busy low -> idata and idata_valid=1 in cycle N+1.
REQ-015 idata SHALL hold its last value when no fetch is accepted; idata_valid SHALL be 0 in those cycles.
REQ-016 A fetch with iaddr[15:ADDR_BITS+1] nonzero SHALL return NOP_WORD; memory is not read.
REQ-017 fetch_req while busy=1 SHALL be ignored: no idata_valid pulse, idata unchanged.
REQ-018 Loader FSM states SHALL be IDLE, COUNT, HI, LO.
REQ-019 IDLE: load_start -> COUNT, busy=1, write pointer=0, load_count=0.
REQ-020 COUNT: on byte_valid, latch N=byte_in (0 means full depth); if N > depth, clamp to depth; -> HI.
REQ-021 HI: on byte_valid, latch high byte -> LO.
REQ-022 LO: on byte_valid, write {high, byte_in} at the write pointer, increment pointer and load_count; if load_count reaches N -> IDLE with busy=0 the next cycle, else -> HI.
REQ-023 States SHALL wait indefinitely without byte_valid; no timeout.
REQ-024 load_start in any non-IDLE state SHALL restart at COUNT with pointer=0; a partially received word SHALL be discarded; already-written words SHALL remain.
REQ-025 load_start and byte_valid in the same cycle: load_start wins and the byte is discarded.
REQ-026 byte_valid in IDLE SHALL be ignored.
REQ-027 The write pointer SHALL never wrap; writes stop exactly at N words.

Reset
REQ-028 On reset: FSM=IDLE, busy=0, idata=0, idata_valid=0, load_count=0, write pointer=0.
REQ-029 Reset SHALL NOT alter memory contents; at configuration every word = NOP_WORD.
REQ-030 Reset during a load SHALL abort it; a half-received word SHALL NOT be written.

Structure
REQ-031 Loader state encoding, NOP_WORD default and instruction-field widths (3/3/3/7) SHALL live in the shared processor package.
REQ-032 The storage array SHALL be one sub-module, imem_ram (1 write port, 1 synchronous read port); FSM and fetch logic in imem_loadable.

Verification
REQ-033 Load: load_start, bytes 03,61,A0,61,03,D6,A2 -> busy low 1 cycle after the last byte, load_count=3; fetch iaddr 0x0002 -> idata=0x6103, valid next cycle.
REQ-034 Out-of-range: ADDR_BITS=6, fetch iaddr 0x0080 -> idata=0x0002; fetch iaddr 0x0005 -> word 2 (iaddr[0] ignored).
REQ-035 Busy fetch: fetch_req during load -> idata_valid stays 0, idata unchanged.
REQ-036 Reset after HI byte 0x11 -> busy=0, target word still holds its prior value; earlier words preserved.
REQ-037 Count 0, ADDR_BITS=6 -> busy drops only after the 129th byte, load_count=64; count 0xFF -> clamped to 64.
REQ-038 load_start mid-load after 2 words -> load restarts, word 0 is overwritten by the next load.
